// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg: shared pixel width, streamer state encoding and default pad value.
package pix_stream_pkg;
  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] PAD_DEFAULT = 8'h00;
  typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;
endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port frame store, one write port, synchronous read (1-cycle latency).
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later (read-before-write).
module frame_ram
  import pix_stream_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/raster_pixel_streamer.sv
// raster_pixel_streamer: streams a stored frame in raster order with no gaps, then pads to drain the filter.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_addr/wr_data load the frame, wr_err flags writes dropped while busy;
// start launches a frame; busy/done report progress; pixel_out with pix_valid/flush/sof/eol/col/row feed the filter.
module raster_pixel_streamer
  import pix_stream_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int LINES = 256,
  parameter logic [PIX_W-1:0] PAD_VALUE = PAD_DEFAULT,
  parameter int FLUSH_LINES = 2,
  parameter int FLUSH_EXTRA = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [$clog2(LINE_W*LINES)-1:0]   wr_addr,
  input  logic [PIX_W-1:0]                  wr_data,
  output logic                              wr_err,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [PIX_W-1:0]                  pixel_out,
  output logic                              pix_valid,
  output logic                              flush,
  output logic                              sof,
  output logic                              eol,
  output logic [$clog2(LINE_W)-1:0]         col,
  output logic [$clog2(LINES)-1:0]          row
);
  localparam int N = LINE_W * LINES;
  localparam int F = FLUSH_LINES * LINE_W + FLUSH_EXTRA;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(LINES);
  localparam int CNT_W = $clog2((N > F ? N : F) + 1);
  state_t state;
  logic [AW-1:0] rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0] ncol;
  logic [RW-1:0] nrow;
  frame_ram #(.DEPTH(N), .AW(AW)) u_ram (
    .clk(clk), .we(wr_en && !busy), .waddr(wr_addr), .wdata(wr_data),
    .raddr(rd_addr), .rdata(rd_data)
  );
  // Position of the pixel about to be emitted, derived from the one currently on the output.
  always_comb begin
    ncol = (cnt == '0) ? '0 : (col == CW'(LINE_W - 1) ? '0 : col + 1'b1);
    nrow = (cnt == '0) ? '0 : (col == CW'(LINE_W - 1) ? row + 1'b1 : row);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_addr <= '0;
      cnt <= '0;
      pixel_out <= PAD_VALUE;
      pix_valid <= 1'b0;
      flush <= 1'b0;
      sof <= 1'b0;
      eol <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wr_err <= 1'b0;
      col <= '0;
      row <= '0;
    end else begin
      wr_err <= wr_en && busy;
      pixel_out <= PAD_VALUE;
      pix_valid <= 1'b0;
      flush <= 1'b0;
      sof <= 1'b0;
      eol <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          rd_addr <= '0;
          cnt <= '0;
          col <= '0;
          row <= '0;
          if (start) begin
            state <= PRIME;
            busy <= 1'b1;
          end
        end
        // Address 0 is read here, one edge after start, so a write on the start edge is seen.
        PRIME: begin
          rd_addr <= AW'(1);
          state <= STREAM;
        end
        STREAM: begin
          pixel_out <= rd_data;
          pix_valid <= 1'b1;
          sof <= (cnt == '0);
          eol <= (ncol == CW'(LINE_W - 1));
          col <= ncol;
          row <= nrow;
          rd_addr <= (rd_addr == AW'(N - 1)) ? rd_addr : rd_addr + 1'b1;
          cnt <= (cnt == CNT_W'(N - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= FLUSH;
        end
        // F pad cycles, then one extra edge that raises done while entering DONE,
        // so the done cycle is spent outside IDLE and start is ignored there.
        FLUSH: begin
          col <= '0;
          row <= '0;
          if (cnt == CNT_W'(F)) begin
            cnt <= '0;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else begin
            flush <= 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
